stride_prefetch_predictor: RTL and testbench
============================================

// Module: stride_prefetch_predictor
// PURPOSE
//  Stride-detecting access-pattern predictor; sits directly upstream of prefetch_buffer and drives its predict_* port.
//  Watches the demand-access stream of the execution unit, tracks up to NUM_STREAMS independent streams, and learns a
//  constant stride per stream. Once the stride is confident, it issues next-address predictions via valid/ready.
// PARAMETERS
//  NUM_STREAMS  4   independent stream-table entries; power of two, >=2
//  ADDR_WIDTH   32  address width; must equal prefetch_buffer ADDR_WIDTH
//  CONF_BITS    2   confidence counter width; saturates at 2^CONF_BITS-1
//  CONF_THRESH  2   confidence >= CONF_THRESH enables predictions; 1..2^CONF_BITS-1
//  LINE_BYTES   64  value driven on predict_size_o
// PORTS
//  clk_i            in   1                      clock
//  rst_ni           in   1                      reset, asynchronous, active-low
//  flush_i          in   1                      clear all stream state and the pending prediction
//  access_valid_i   in   1                      demand access observed; no ready, one access accepted every cycle
//  access_addr_i    in   ADDR_WIDTH             demand byte address
//  access_sid_i     in   $clog2(NUM_STREAMS)    stream id (e.g. operand A/B/C, output)
//  predict_valid_o  out  1                      prediction pending
//  predict_addr_o   out  ADDR_WIDTH             predicted next demand address
//  predict_size_o   out  ADDR_WIDTH             = LINE_BYTES
//  predict_ready_i  in   1                      downstream accepts prediction
//  stat_issued_o    out  32                     [PREFETCH_PRED_STATS_EN only] predictions handed off
//  stat_dropped_o   out  32                     [PREFETCH_PRED_STATS_EN only] predictions discarded
// BEHAVIOUR
//  - Reset: table entries invalid, last_addr/stride/conf = 0; predict_valid_o=0, predict_addr_o=0, counters=0.
//  - Entry = {valid, last_addr, stride (signed ADDR_WIDTH), conf}. Per entry, the state is INIT (!valid),
//    TRAIN (valid, conf<CONF_THRESH) or STEADY (conf>=CONF_THRESH).
//  - Access to an INIT entry: last_addr<=addr, stride<=0, conf<=0, valid<=1. No prediction.
//  - Access to a valid entry: d = addr - last_addr, modulo 2^ADDR_WIDTH, read as signed.
//    d==stride && d!=0: conf<=sat_inc(conf). Otherwise: stride<=d, conf<=0. Always: last_addr<=addr.
//  - Prediction candidate: when the post-update conf >= CONF_THRESH, cand = addr + stride (wraps modulo 2^ADDR_WIDTH).
//  - Latency: candidate appears on predict_* the cycle after access_valid_i (registered single-entry output slot).
//  - Output slot follows valid/ready. While valid && !ready, addr and valid hold stable.
//    The slot is free if it is empty or if a handshake occurs in the same cycle.
//  - Candidate with slot free: load slot. Candidate with slot occupied: drop the candidate and count it as dropped.
//    The older prediction always wins.
//  - Duplicate: candidate equal to the pending predict_addr_o (slot not freed this cycle) is dropped silently (not counted).
//  - Zero stride never predicts; a repeated address resets conf to 0.
//  - flush_i has priority over an access in the same cycle. Next cycle: all entries INIT, predict_valid_o=0.
//    The pending prediction is discarded; a handshake in the flush cycle still completes.
//  - Reset mid-operation: immediate return to reset values; no partial entry update survives.
// CONFIGURATION
//  PREFETCH_PRED_STATS_EN defined: stat_issued_o increments on each predict handshake; stat_dropped_o on each
//  occupied-slot drop. Both saturate at 2^32-1 and clear on reset and on flush_i.
//  Undefined: stat ports and counters are absent; functional behaviour is identical.
// STRUCTURE
//  Shared package garuda_prefetch_pkg: stream_entry_t struct, stride_t (signed ADDR_WIDTH), LINE_BYTES default,
//  stream-id enum (SID_A, SID_B, SID_C, SID_OUT).
//  One sub-module is natural: stride_stream_entry (one table entry: update rule, conf saturation, candidate out),
//  instantiated NUM_STREAMS times. Output slot, arbitration and stats stay in the top module.
// TESTING
//  1 sid0 accesses 0x1000,0x1040,0x1080,0x10C0, predict_ready_i=1 -> first prediction 0x1100 after 4th access,
//    predict_size_o=64; none earlier.
//  2 sid1 accesses 0x2000,0x1FF0,0x1FE0,0x1FD0 (stride -16) -> prediction 0x1FC0; then 0x1FD0 again -> conf=0, no prediction.
//  3 steady sid0, predict_ready_i=0 for 3 accesses -> predict_addr_o holds the first value;
//    later candidates dropped; stat_dropped_o=2 (STATS_EN).
//  4 interleave sid0 (stride 64) and sid2 (stride 128) each cycle -> independent training; both streams predict correctly.
//  5 flush_i in the same cycle as a steady access -> no prediction next cycle; the next 2 accesses retrain from INIT.
//  6 addr 0xFFFF_FFC0, stride 64, STEADY -> prediction 0x0000_0000 (wrap); async reset mid-burst
//    -> predict_valid_o=0 immediately.

Source files
------------

// File: rtl/garuda_prefetch_pkg.sv
// Shared prefetch types: stream entry layout, signed stride, stream ids, per-entry state.
// Used by stride_prefetch_predictor (optional stats: PREFETCH_PRED_STATS_EN).
package garuda_prefetch_pkg;

    localparam int ADDR_WIDTH_DEF = 32;
    localparam int CONF_BITS_DEF  = 2;
    localparam int LINE_BYTES_DEF = 64;

    typedef logic signed [ADDR_WIDTH_DEF-1:0] stride_t;

    typedef enum logic [1:0] {
        SID_A,
        SID_B,
        SID_C,
        SID_OUT
    } sid_e;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_TRAIN,
        ST_STEADY
    } entry_state_e;

    typedef struct packed {
        logic                      valid;
        logic [ADDR_WIDTH_DEF-1:0] last_addr;
        stride_t                   stride;
        logic [CONF_BITS_DEF-1:0]  conf;
    } stream_entry_t;

endpackage

// File: rtl/stride_prefetch_predictor_if.sv
// Demand-access stream in, next-address prediction out (valid/ready).
// Handshake: a prediction transfers on a rising edge where predict_valid_o && predict_ready_i; while
// valid is high and ready low, addr stays stable. Accesses have no ready and are taken every cycle.
interface stride_prefetch_predictor_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int SID_WIDTH  = 2
);

    logic                  access_valid_i;
    logic [ADDR_WIDTH-1:0] access_addr_i;
    logic [SID_WIDTH-1:0]  access_sid_i;
    logic                  predict_valid_o;
    logic [ADDR_WIDTH-1:0] predict_addr_o;
    logic [ADDR_WIDTH-1:0] predict_size_o;
    logic                  predict_ready_i;

    modport master (
        output access_valid_i,
        output access_addr_i,
        output access_sid_i,
        output predict_ready_i,
        input  predict_valid_o,
        input  predict_addr_o,
        input  predict_size_o
    );

    modport slave (
        input  access_valid_i,
        input  access_addr_i,
        input  access_sid_i,
        input  predict_ready_i,
        output predict_valid_o,
        output predict_addr_o,
        output predict_size_o
    );

endinterface

// File: rtl/stride_stream_entry.sv
// One stream-table entry: learns a constant stride, saturating confidence, and offers a
// combinational next-address candidate in the cycle of a qualifying access.
module stride_stream_entry
    import garuda_prefetch_pkg::*;
#(
    parameter int ADDR_WIDTH  = 32,
    parameter int CONF_BITS   = 2,
    parameter int CONF_THRESH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  hit_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic                  cand_valid_o,
    output logic [ADDR_WIDTH-1:0] cand_addr_o,
    output entry_state_e          state_o
);

    localparam logic [CONF_BITS-1:0] THRESH   = CONF_BITS'(CONF_THRESH);
    localparam logic [CONF_BITS-1:0] CONF_MAX = '1;

    logic                         valid_q, valid_d;
    logic [ADDR_WIDTH-1:0]        last_addr_q, last_addr_d;
    logic signed [ADDR_WIDTH-1:0] stride_q, stride_d;
    logic [CONF_BITS-1:0]         conf_q, conf_d;
    logic signed [ADDR_WIDTH-1:0] delta;

    always_comb begin
        valid_d     = valid_q;
        last_addr_d = last_addr_q;
        stride_d    = stride_q;
        conf_d      = conf_q;
        // Modular difference reinterpreted as signed, so descending streams train too.
        delta       = addr_i - last_addr_q;
        if (flush_i) begin
            valid_d     = 1'b0;
            last_addr_d = '0;
            stride_d    = '0;
            conf_d      = '0;
        end else if (hit_i) begin
            valid_d     = 1'b1;
            last_addr_d = addr_i;
            if (!valid_q) begin
                stride_d = '0;
                conf_d   = '0;
            end else if ((delta == stride_q) && (delta != '0)) begin
                if (conf_q != CONF_MAX) conf_d = conf_q + CONF_BITS'(1);
            end else begin
                stride_d = delta;
                conf_d   = '0;
            end
        end
    end

    assign cand_valid_o = hit_i && !flush_i && valid_q && (conf_d >= THRESH);
    assign cand_addr_o  = addr_i + stride_d;

    always_comb begin
        state_o = ST_INIT;
        if (valid_q) state_o = (conf_q >= THRESH) ? ST_STEADY : ST_TRAIN;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q     <= 1'b0;
            last_addr_q <= '0;
            stride_q    <= '0;
            conf_q      <= '0;
        end else begin
            valid_q     <= valid_d;
            last_addr_q <= last_addr_d;
            stride_q    <= stride_d;
            conf_q      <= conf_d;
        end
    end

endmodule

// File: rtl/stride_prefetch_predictor.sv
// Stride prefetch predictor: NUM_STREAMS stride entries feeding one registered prediction slot.
// Define PREFETCH_PRED_STATS_EN to add saturating issued/dropped counters.
module stride_prefetch_predictor
    import garuda_prefetch_pkg::*;
#(
    parameter int NUM_STREAMS = 4,
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int CONF_BITS   = CONF_BITS_DEF,
    parameter int CONF_THRESH = 2,
    parameter int LINE_BYTES  = LINE_BYTES_DEF
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    stride_prefetch_predictor_if.slave   bus,
    output logic [NUM_STREAMS-1:0][1:0]  dbg_state_o
`ifdef PREFETCH_PRED_STATS_EN
    ,
    output logic [31:0]                  stat_issued_o,
    output logic [31:0]                  stat_dropped_o
`endif
);

    localparam int SID_W = $clog2(NUM_STREAMS);

    logic [NUM_STREAMS-1:0] hit;
    logic [NUM_STREAMS-1:0] cand_valid_vec;
    logic [ADDR_WIDTH-1:0]  cand_addr_arr [NUM_STREAMS];
    entry_state_e           state_arr [NUM_STREAMS];

    for (genvar g = 0; g < NUM_STREAMS; g++) begin : g_entry
        assign hit[g] = bus.access_valid_i && !flush_i && (bus.access_sid_i == SID_W'(g));

        stride_stream_entry #(
            .ADDR_WIDTH  (ADDR_WIDTH),
            .CONF_BITS   (CONF_BITS),
            .CONF_THRESH (CONF_THRESH)
        ) u_entry (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .flush_i      (flush_i),
            .hit_i        (hit[g]),
            .addr_i       (bus.access_addr_i),
            .cand_valid_o (cand_valid_vec[g]),
            .cand_addr_o  (cand_addr_arr[g]),
            .state_o      (state_arr[g])
        );

        assign dbg_state_o[g] = state_arr[g];
    end

    logic                  cand_valid;
    logic [ADDR_WIDTH-1:0] cand_addr;
    logic                  handshake;
    logic                  slot_free;
    logic                  pred_valid_q, pred_valid_d;
    logic [ADDR_WIDTH-1:0] pred_addr_q, pred_addr_d;

    // At most one entry is hit per cycle, so the sid selects the only possible candidate.
    assign cand_valid = |cand_valid_vec;
    assign cand_addr  = cand_addr_arr[bus.access_sid_i];
    assign handshake  = pred_valid_q && bus.predict_ready_i;
    assign slot_free  = !pred_valid_q || handshake;

    always_comb begin
        pred_valid_d = pred_valid_q && !handshake;
        pred_addr_d  = pred_addr_q;
        if (flush_i) begin
            pred_valid_d = 1'b0;
        end else if (cand_valid && slot_free) begin
            pred_valid_d = 1'b1;
            pred_addr_d  = cand_addr;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pred_valid_q <= 1'b0;
            pred_addr_q  <= '0;
        end else begin
            pred_valid_q <= pred_valid_d;
            pred_addr_q  <= pred_addr_d;
        end
    end

    assign bus.predict_valid_o = pred_valid_q;
    assign bus.predict_addr_o  = pred_addr_q;
    assign bus.predict_size_o  = ADDR_WIDTH'(LINE_BYTES);

`ifdef PREFETCH_PRED_STATS_EN
    logic [31:0] issued_q, issued_d;
    logic [31:0] dropped_q, dropped_d;
    logic        drop;

    // A candidate equal to the pending address is a duplicate, not a loss.
    assign drop = cand_valid && !slot_free && (cand_addr != pred_addr_q);

    always_comb begin
        issued_d  = issued_q;
        dropped_d = dropped_q;
        if (flush_i) begin
            issued_d  = '0;
            dropped_d = '0;
        end else begin
            if (handshake && (issued_q != '1)) issued_d = issued_q + 32'd1;
            if (drop && (dropped_q != '1))     dropped_d = dropped_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            issued_q  <= '0;
            dropped_q <= '0;
        end else begin
            issued_q  <= issued_d;
            dropped_q <= dropped_d;
        end
    end

    assign stat_issued_o  = issued_q;
    assign stat_dropped_o = dropped_q;
`endif

endmodule

// File: tb/tb_stride_prefetch_predictor.sv
// Directed bench for stride_prefetch_predictor; stats checks active when PREFETCH_PRED_STATS_EN is defined.
module tb_stride_prefetch_predictor;
    import garuda_prefetch_pkg::*;

    logic       clk_i;
    logic       rst_ni;
    logic       flush_i;
    logic [7:0] dbg_state;
`ifdef PREFETCH_PRED_STATS_EN
    logic [31:0] stat_issued;
    logic [31:0] stat_dropped;
`endif

    int pass_cnt;
    int total_cnt;

    stride_prefetch_predictor_if #(.ADDR_WIDTH(32), .SID_WIDTH(2)) bus_if ();

    stride_prefetch_predictor dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .bus         (bus_if),
        .dbg_state_o (dbg_state)
`ifdef PREFETCH_PRED_STATS_EN
        ,
        .stat_issued_o  (stat_issued),
        .stat_dropped_o (stat_dropped)
`endif
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic acc(input logic [1:0] sid, input logic [31:0] addr);
        bus_if.access_valid_i = 1'b1;
        bus_if.access_sid_i   = sid;
        bus_if.access_addr_i  = addr;
        @(posedge clk_i);
        #1;
        bus_if.access_valid_i = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        flush_i = 1'b0;
        bus_if.access_valid_i = 1'b0;
        bus_if.access_sid_i = '0;
        bus_if.access_addr_i = '0;
        bus_if.predict_ready_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        total_cnt++;
        if (bus_if.predict_valid_o !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus_if.predict_valid_o);
        else pass_cnt++;
        total_cnt++;
        if (bus_if.predict_addr_o !== 32'h0) $display("FAIL reset_addr: got %h expected 00000000", bus_if.predict_addr_o);
        else pass_cnt++;
        total_cnt++;
        if (dbg_state !== 8'h00) $display("FAIL reset_state: got %h expected 00", dbg_state);
        else pass_cnt++;
`ifdef PREFETCH_PRED_STATS_EN
        total_cnt++;
        if (stat_issued !== 32'd0 || stat_dropped !== 32'd0)
            $display("FAIL reset_stats: got %0d/%0d expected 0/0", stat_issued, stat_dropped);
        else pass_cnt++;
`endif
        @(negedge clk_i);
        rst_ni = 1'b1;
        idle();
    endtask

    task automatic test_ascending();
        logic [31:0] addrs [4];
        addrs = '{32'h1000, 32'h1040, 32'h1080, 32'h10C0};
        bus_if.predict_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            acc(SID_A, addrs[i]);
            total_cnt++;
            if (bus_if.predict_valid_o !== 1'b0)
                $display("FAIL asc_early_%0d: got valid %b expected 0", i, bus_if.predict_valid_o);
            else pass_cnt++;
        end
        acc(SID_A, addrs[3]);
        total_cnt++;
        if (bus_if.predict_valid_o !== 1'b1 || bus_if.predict_addr_o !== 32'h1100)
            $display("FAIL asc_pred: got valid %b addr %h expected 1 00001100", bus_if.predict_valid_o, bus_if.predict_addr_o);
        else pass_cnt++;
        total_cnt++;
        if (bus_if.predict_size_o !== 32'd64) $display("FAIL asc_size: got %0d expected 64", bus_if.predict_size_o);
        else pass_cnt++;
        total_cnt++;
        if (dbg_state[1:0] !== ST_STEADY) $display("FAIL asc_state: got %0d expected %0d", dbg_state[1:0], ST_STEADY);
        else pass_cnt++;
        idle();
        total_cnt++;
        if (bus_if.predict_valid_o !== 1'b0) $display("FAIL asc_consumed: got valid %b expected 0", bus_if.predict_valid_o);
        else pass_cnt++;
    endtask

    task automatic test_descending();
        logic [31:0] addrs [4];
        addrs = '{32'h2000, 32'h1FF0, 32'h1FE0, 32'h1FD0};
        for (int i = 0; i < 3; i++) acc(SID_B, addrs[i]);
        total_cnt++;
        if (bus_if.predict_valid_o !== 1'b0) $display("FAIL desc_early: got valid %b expected 0", bus_if.predict_valid_o);
        else pass_cnt++;
        acc(SID_B, addrs[3]);
        total_cnt++;
        if (bus_if.predict_valid_o !== 1'b1 || bus_if.predict_addr_o !== 32'h1FC0)
            $display("FAIL desc_pred: got valid %b addr %h expected 1 00001FC0", bus_if.predict_valid_o, bus_if.predict_addr_o);
        else pass_cnt++;
        acc(SID_B, 32'h1FD0);
        total_cnt++;
        if (bus_if.predict_valid_o !== 1'b0) $display("FAIL desc_repeat: got valid %b expected 0", bus_if.predict_valid_o);
        else pass_cnt++;
        total_cnt++;
        if (dbg_state[3:2] !== ST_TRAIN) $display("FAIL desc_state: got %0d expected %0d", dbg_state[3:2], ST_TRAIN);
        else pass_cnt++;
    endtask

    task automatic test_backpressure();
        bus_if.predict_ready_i = 1'b0;
        acc(SID_A, 32'h1100);
        total_cnt++;
        if (bus_if.predict_valid_o !== 1'b1 || bus_if.predict_addr_o !== 32'h1140)
            $display("FAIL bp_first: got valid %b addr %h expected 1 00001140", bus_if.predict_valid_o, bus_if.predict_addr_o);
        else pass_cnt++;
        acc(SID_A, 32'h1140);
        acc(SID_A, 32'h1180);
        total_cnt++;
        if (bus_if.predict_valid_o !== 1'b1 || bus_if.predict_addr_o !== 32'h1140)
            $display("FAIL bp_hold: got valid %b addr %h expected 1 00001140", bus_if.predict_valid_o, bus_if.predict_addr_o);
        else pass_cnt++;
`ifdef PREFETCH_PRED_STATS_EN
        total_cnt++;
        if (stat_dropped !== 32'd2) $display("FAIL bp_dropped: got %0d expected 2", stat_dropped);
        else pass_cnt++;
`endif
        bus_if.predict_ready_i = 1'b1;
        idle();
        total_cnt++;
        if (bus_if.predict_valid_o !== 1'b0) $display("FAIL bp_release: got valid %b expected 0", bus_if.predict_valid_o);
        else pass_cnt++;
`ifdef PREFETCH_PRED_STATS_EN
        total_cnt++;
        if (stat_issued !== 32'd3) $display("FAIL bp_issued: got %0d expected 3", stat_issued);
        else pass_cnt++;
`endif
    endtask

    task automatic test_interleave();
        logic [1:0]  sids [10];
        logic [31:0] addrs [10];
        logic        exp_v [10];
        logic [31:0] exp_a [10];
        sids  = '{SID_A, SID_C, SID_A, SID_C, SID_A, SID_C, SID_A, SID_C, SID_A, SID_C};
        addrs = '{32'h4000, 32'h8000, 32'h4040, 32'h8080, 32'h4080,
                  32'h8100, 32'h40C0, 32'h8180, 32'h4100, 32'h8200};
        exp_v = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        exp_a = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h4100, 32'h8200, 32'h4140, 32'h8280};
        for (int i = 0; i < 10; i++) begin
            acc(sids[i], addrs[i]);
            total_cnt++;
            if (bus_if.predict_valid_o !== exp_v[i] || (exp_v[i] && bus_if.predict_addr_o !== exp_a[i]))
                $display("FAIL interleave_%0d: got valid %b addr %h expected %b %h",
                         i, bus_if.predict_valid_o, bus_if.predict_addr_o, exp_v[i], exp_a[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_flush();
        flush_i = 1'b1;
        acc(SID_A, 32'h4140);
        flush_i = 1'b0;
        total_cnt++;
        if (bus_if.predict_valid_o !== 1'b0) $display("FAIL flush_valid: got valid %b expected 0", bus_if.predict_valid_o);
        else pass_cnt++;
        total_cnt++;
        if (dbg_state !== 8'h00) $display("FAIL flush_state: got %h expected 00", dbg_state);
        else pass_cnt++;
`ifdef PREFETCH_PRED_STATS_EN
        total_cnt++;
        if (stat_issued !== 32'd0 || stat_dropped !== 32'd0)
            $display("FAIL flush_stats: got %0d/%0d expected 0/0", stat_issued, stat_dropped);
        else pass_cnt++;
`endif
        acc(SID_A, 32'h4180);
        acc(SID_A, 32'h41C0);
        total_cnt++;
        if (bus_if.predict_valid_o !== 1'b0 || dbg_state[1:0] !== ST_TRAIN)
            $display("FAIL flush_retrain: got valid %b state %0d expected 0 %0d",
                     bus_if.predict_valid_o, dbg_state[1:0], ST_TRAIN);
        else pass_cnt++;
        acc(SID_A, 32'h4200);
        acc(SID_A, 32'h4240);
        total_cnt++;
        if (bus_if.predict_valid_o !== 1'b1 || bus_if.predict_addr_o !== 32'h4280)
            $display("FAIL flush_repredict: got valid %b addr %h expected 1 00004280", bus_if.predict_valid_o, bus_if.predict_addr_o);
        else pass_cnt++;
        idle();
    endtask

    task automatic test_wrap_reset();
        bus_if.predict_ready_i = 1'b0;
        acc(SID_OUT, 32'hFFFF_FF00);
        acc(SID_OUT, 32'hFFFF_FF40);
        acc(SID_OUT, 32'hFFFF_FF80);
        total_cnt++;
        if (bus_if.predict_valid_o !== 1'b0) $display("FAIL wrap_early: got valid %b expected 0", bus_if.predict_valid_o);
        else pass_cnt++;
        acc(SID_OUT, 32'hFFFF_FFC0);
        total_cnt++;
        if (bus_if.predict_valid_o !== 1'b1 || bus_if.predict_addr_o !== 32'h0000_0000)
            $display("FAIL wrap_pred: got valid %b addr %h expected 1 00000000", bus_if.predict_valid_o, bus_if.predict_addr_o);
        else pass_cnt++;
        #3;
        rst_ni = 1'b0;
        #1;
        total_cnt++;
        if (bus_if.predict_valid_o !== 1'b0) $display("FAIL async_reset_valid: got valid %b expected 0", bus_if.predict_valid_o);
        else pass_cnt++;
        total_cnt++;
        if (dbg_state !== 8'h00) $display("FAIL async_reset_state: got %h expected 00", dbg_state);
        else pass_cnt++;
        @(negedge clk_i);
        rst_ni = 1'b1;
        bus_if.predict_ready_i = 1'b1;
        idle();
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        test_reset();
        test_ascending();
        test_descending();
        test_backpressure();
        test_interleave();
        test_flush();
        test_wrap_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
